// File: rtl/screen_fill_engine_pkg.sv
// Shared screen geometry, fill FSM states and address helpers.
// Imported by the fill engine and by the display reader.
package screen_pkg;

    localparam int WIDTH         = 488;
    localparam int HEIGHT        = 280;
    localparam int PIX_PER_WORD  = 8;
    localparam int WORDS_PER_ROW = WIDTH / PIX_PER_WORD;

    localparam int SW = 11;
    localparam int WW = SW - 3;
    localparam int AW = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_WR,
        S_DONE
    } fill_state_e;

    // Rows start word-aligned, so the address is row base plus word index.
    function automatic logic [AW-1:0] word_addr(
        input logic [SW-1:0] y,
        input logic [WW-1:0] w
    );
        return AW'(y) * AW'(WORDS_PER_ROW) + AW'(w);
    endfunction

    // Nibble n is covered when pixel w*8+n lies inside [xs, xe].
    function automatic logic [7:0] word_mask(
        input logic [WW-1:0] w,
        input logic [SW-1:0] xs,
        input logic [SW-1:0] xe
    );
        logic [7:0]    m;
        logic [SW-1:0] px;
        m = 8'h00;
        for (int n = 0; n < PIX_PER_WORD; n++) begin
            px   = {w, 3'(n)};
            m[n] = (px >= xs) && (px <= xe);
        end
        return m;
    endfunction

endpackage

// File: rtl/screen_fill_engine_if.sv
// Request and RAM port-A bundle of the screen fill engine.
// slave = engine side, master = requester / RAM side.
interface screen_fill_if #(
    parameter int SCREEN_WIDTH = 11,
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 32
);
    logic                    start;
    logic [SCREEN_WIDTH-1:0] x0;
    logic [SCREEN_WIDTH-1:0] y0;
    logic [SCREEN_WIDTH-1:0] x1;
    logic [SCREEN_WIDTH-1:0] y1;
    logic [3:0]              color_id;
    logic                    busy;
    logic                    done;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    modport master (
        output start, x0, y0, x1, y1, color_id, ram_rdata,
        input  busy, done, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  start, x0, y0, x1, y1, color_id, ram_rdata,
        output busy, done, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/screen_fill_engine_nibble_merge.sv
// Replaces the masked nibbles of a packed 8-pixel word with one colour.
// With an all-ones mask the old word is irrelevant.
module nibble_merge (
    input  logic [31:0] old_word_i,
    input  logic [7:0]  mask_i,
    input  logic [3:0]  color_i,
    output logic [31:0] new_word_o
);

    // Per-nibble select between old pixel and fill colour.
    always_comb begin
        new_word_o = old_word_i;
        for (int n = 0; n < 8; n++) begin
            if (mask_i[n]) begin
                new_word_o[4*n +: 4] = color_i;
            end
        end
    end

endmodule

// File: rtl/screen_fill_engine.sv
// Rectangle fill engine writing 4bpp pixels into screen RAM port A.
// Full words are written blind, partial words are read-modify-written.
module screen_fill_engine
    import screen_pkg::*;
#(
    parameter int SCREEN_WIDTH = 11,
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 32,
    parameter int WIDTH        = 488,
    parameter int HEIGHT       = 280
) (
    input  logic         clk,
    input  logic         rst,
    screen_fill_if.slave bus
);

    localparam int XW = SCREEN_WIDTH;
    localparam int WI = SCREEN_WIDTH - 3;
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [XW-1:0] YMAX = XW'(HEIGHT - 1);

    fill_state_e           state_q;
    logic [XW-1:0]         x0_q, y0_q, x1_q, y1_q;
    logic [XW-1:0]         xe_q, ye_q;
    logic [3:0]            col_q;
    logic [XW-1:0]         cur_y_q;
    logic [WI-1:0]         cur_w_q;
    logic [7:0]            mask_q;
    logic                  busy_q, done_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [XW-1:0]         xe_d, ye_d;
    logic                  empty_d;
    logic [7:0]            fmask_d;
    logic                  last_w_d, last_row_d;
    logic [WI-1:0]         nw_d;
    logic [XW-1:0]         ny_d;
    logic [7:0]            nmask_d;
    logic [DATA_WIDTH-1:0] merged;

    // Clip the latched rectangle and classify the first word.
    always_comb begin
        xe_d    = (x1_q > XMAX) ? XMAX : x1_q;
        ye_d    = (y1_q > YMAX) ? YMAX : y1_q;
        empty_d = (x0_q > XMAX) || (y0_q > YMAX) ||
                  (x0_q > xe_d) || (y0_q > ye_d);
        fmask_d = word_mask(x0_q[XW-1:3], x0_q, xe_d);
    end

    // Next word in row-major order and its mask, for bubble-free WR.
    always_comb begin
        last_w_d   = (cur_w_q >= xe_q[XW-1:3]);
        last_row_d = (cur_y_q >= ye_q);
        nw_d       = last_w_d ? x0_q[XW-1:3] : cur_w_q + WI'(1);
        ny_d       = last_w_d ? cur_y_q + XW'(1) : cur_y_q;
        nmask_d    = word_mask(nw_d, x0_q, xe_q);
    end

    nibble_merge u_merge (
        .old_word_i (bus.ram_rdata),
        .mask_i     (mask_q),
        .color_i    (col_q),
        .new_word_o (merged)
    );

    // Fill sequencer with registered status and RAM controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            col_q   <= '0;
            cur_y_q <= '0;
            cur_w_q <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        x0_q    <= bus.x0;
                        y0_q    <= bus.y0;
                        x1_q    <= bus.x1;
                        y1_q    <= bus.y1;
                        col_q   <= bus.color_id;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    xe_q <= xe_d;
                    ye_q <= ye_d;
                    if (empty_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cur_y_q <= y0_q;
                        cur_w_q <= x0_q[XW-1:3];
                        mask_q  <= fmask_d;
                        addr_q  <= ADDR_WIDTH'(word_addr(y0_q, x0_q[XW-1:3]));
                        we_q    <= (fmask_d == 8'hFF);
                        state_q <= (fmask_d == 8'hFF) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    we_q    <= 1'b1;
                    state_q <= S_WR;
                end
                S_WR: begin
                    wdata_q <= merged;
                    if (last_w_d && last_row_d) begin
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cur_w_q <= nw_d;
                        cur_y_q <= ny_d;
                        mask_q  <= nmask_d;
                        addr_q  <= ADDR_WIDTH'(word_addr(ny_d, nw_d));
                        we_q    <= (nmask_d == 8'hFF);
                        state_q <= (nmask_d == 8'hFF) ? S_WR : S_RD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = (state_q == S_WR) ? merged : wdata_q;

endmodule

// File: doc/screen_fill_engine.md
Name: screen_fill_engine

Overview:
- Write-side producer for the 4-bit-per-pixel screen RAM scanned by the VGA read path; fills an axis-aligned rectangle of a 488x280 screen with one colour ID.
- Packing: 8 pixels per 32-bit word, pixel n at bits [4n+3:4n].
- Word address = (y*488 + x)/8; every row starts word-aligned, so addr = y*61 + x[10:3].
- Owns the write/read port A of the dual-port screen RAM. The display reader keeps port B.

Parameters:
- SCREEN_WIDTH, 11, coordinate width.
- ADDR_WIDTH, 25, RAM word-address width.
- DATA_WIDTH, 32, RAM word width. Fixed at 8 nibbles.
- WIDTH, 488, visible pixels per row. Must be a multiple of 8.
- HEIGHT, 280, visible rows.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: one-cycle request pulse. Sampled only in IDLE.
- x0, in, SCREEN_WIDTH: rectangle left edge, inclusive.
- y0, in, SCREEN_WIDTH: rectangle top edge, inclusive.
- x1, in, SCREEN_WIDTH: rectangle right edge, inclusive.
- y1, in, SCREEN_WIDTH: rectangle bottom edge, inclusive.
- color_id, in, 4: fill colour index.
- busy, out, 1: high while a request is in progress.
- done, out, 1: one-cycle pulse when a request completes.
- ram_addr, out, ADDR_WIDTH: port-A word address.
- ram_wdata, out, DATA_WIDTH: port-A write data.
- ram_we, out, 1: port-A write enable.
- ram_rdata, in, DATA_WIDTH: port-A read data. Valid the cycle after the address is presented (synchronous RAM, 1-cycle latency).

Behaviour:
- Reset values: busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0. State = IDLE.
- rst takes effect at the next edge from any state. Any in-flight request is abandoned; partial fills are not undone.
- Clock and reset are one clock, synchronous, active-high, named clk and rst as stated in Ports.
- States: IDLE, SETUP, RD, WR, DONE.
- IDLE:
  - On start=1, latch x0, y0, x1, y1, color_id. Go to SETUP and set busy=1.
  - start while busy is ignored.
- SETUP (1 cycle):
  - Clip: xe = min(x1, WIDTH-1), ye = min(y1, HEIGHT-1).
  - Empty request if x0 >= WIDTH, y0 >= HEIGHT, x0 > xe, or y0 > ye. An empty request goes straight to DONE with no RAM access.
  - Otherwise set cur_y = y0 and cur_word = x0[10:3]. Compute the nibble mask for the first word.
- Nibble mask for word w:
  - Bit n is set iff w*8+n lies in [x0, xe].
  - If mask == 8'hFF, go to WR directly (full word, no read, 1 cycle).
  - Otherwise go to RD.
- RD:
  - Drive ram_addr = cur_y*61 + cur_word, ram_we = 0. Next state WR.
- WR:
  - Drive the same address and ram_we = 1.
  - ram_wdata: for full words, color_id replicated ×8. For partial words, ram_rdata with the masked nibbles replaced by color_id (merge is combinational from ram_rdata).
  - Then advance:
    - If cur_word < xe[10:3], go to the next word.
    - Else, if cur_y < ye, go to the next row with cur_word = x0[10:3].
    - Else go to DONE.
  - The next word's mask is evaluated in the same cycle, so consecutive words have no bubble.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Cost per row: 1 cycle per full word, 2 cycles per partial word.
- Traversal order is row-major, ascending address.
- Address arithmetic is computed at ADDR_WIDTH. The maximum address is 279*61+60 = 17079.
- ram_we is high only in WR. ram_addr and ram_wdata hold their last value otherwise.

Decomposition:
- Package screen_pkg holds:
  - WIDTH, HEIGHT, WORDS_PER_ROW=61, PIX_PER_WORD=8.
  - The state enum.
  - A function for word address from (y, word index).
- The display reader imports the same package.
- One sub-module, nibble_merge: combinational (old_word, mask[7:0], color_id) -> new_word. Reused for the mask==FF path by passing any old_word.

Test Plan:
- (0,0)-(7,0), color 5:
  - Exactly one write: addr 0, wdata 0x55555555, no RD cycle.
  - Timing: start sampled at cycle 0, WR at cycle 2, done at cycle 3.
- (3,1)-(4,1), color A, RAM[61] preset 0x12345678:
  - One read of addr 61, then a write to addr 61 with 0x123AA678.
  - All other words unchanged.
- (6,2)-(9,3), color F, background zero:
  - Read/write pairs in order at addr 122, 123, 183, 184.
  - Write data 0xFF000000, 0x000000FF, 0xFF000000, 0x000000FF.
- Clipping, (0,279)-(1000,400), color 3:
  - 61 full-word writes, addr 17019..17079, each 0x33333333, no reads.
  - done 63 cycles after start.
- Empty requests, x0=500 or x0=10 with x1=5:
  - done at cycle 2 after start.
  - ram_we never asserted.
  - busy high exactly for cycle 1.
- Robustness:
  - start asserted during busy has no effect.
  - rst asserted in WR: ram_we=0, busy=0, done=0 from the next cycle.
  - A new start after reset completes normally.
